// File: rtl/jpeg_dct_seq.sv
// jpeg_dct_seq: block sequencer for the 2-D DCT datapath.
// Row pass: inmem -> DCT -> transpose. Column pass: transpose -> DCT -> quantizer/utmem.
// Every output comes from a flop that is loaded with the decode of the next state.
module jpeg_dct_seq #(
    parameter int unsigned DCT_LAT = 4,
    parameter int unsigned T_LAT   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] blocks_o,
    output logic [8:0]  rdc_o,
    output logic        x_valid_o,
    output logic        mux1_o,
    output logic        twr_o,
    output logic        trd_o,
    output logic        wren_o,
    output logic [4:0]  wrc_o,
    output logic [1:0]  mux2_o,
    output logic [5:0]  rec_idx_o
);
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned WAIT_LAST = T_LAT + DCT_LAT - 1;
    localparam int unsigned XV_AT     = (T_LAT == 0) ? 0 : T_LAT - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RPASS, S_RDRAIN, S_CISSUE, S_CWAIT, S_CWRITE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         col_q, col_d;
    logic [2:0]         twr_cnt_q, twr_cnt_d;
    logic [DCT_LAT-1:0] dly_q, dly_d;
    logic [15:0]        blocks_q, blocks_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         rdc_q, rdc_d;
    logic               x_valid_q, x_valid_d;
    logic               mux1_q, mux1_d;
    logic               trd_q, trd_d;
    logic               wren_q, wren_d;
    logic [4:0]         wrc_q, wrc_d;
    logic [1:0]         mux2_q, mux2_d;
    logic [5:0]         rec_idx_q, rec_idx_d;

    // Next state, cycle/column counters, and the row-strobe delay line that makes twr.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        twr_cnt_d = dly_q[DCT_LAT-1] ? twr_cnt_q + 3'd1 : twr_cnt_q;
        // Only row-pass strobes (mux1 low) enter the line; column strobes never write transpose.
        dly_d     = DCT_LAT'({dly_q, x_valid_q & ~mux1_q});
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RPASS;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            S_RPASS: begin
                if (cnt_q == CNT_W'(15)) begin
                    state_d = S_RDRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RDRAIN: begin
                if (dly_q[DCT_LAT-1] && twr_cnt_q == 3'd7) begin
                    state_d = S_CISSUE;
                end
            end
            S_CISSUE: begin
                state_d = S_CWAIT;
                cnt_d   = '0;
            end
            S_CWAIT: begin
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    state_d = S_CWRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CWRITE: begin
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d = '0;
                    if (col_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CISSUE;
                        col_d   = col_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the next state so each output flop is valid in the state's own cycle.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        blocks_d  = done_d ? blocks_q + 16'd1 : blocks_q;
        rdc_d     = (state_d == S_RPASS) ? cnt_d[3:0] : 4'd0;
        mux1_d    = (state_d == S_CISSUE) || (state_d == S_CWAIT);
        trd_d     = (state_d == S_CISSUE);
        wren_d    = (state_d == S_CWRITE);
        wrc_d     = 5'd0;
        mux2_d    = 2'd0;
        rec_idx_d = 6'd0;
        // Row strobe follows each odd inmem address by one cycle (1-cycle RAM latency).
        x_valid_d = (state_q == S_RPASS) && cnt_q[0];
        if (T_LAT == 0) begin
            x_valid_d = x_valid_d || (state_d == S_CISSUE);
        end else begin
            x_valid_d = x_valid_d || ((state_d == S_CWAIT) && (cnt_d == CNT_W'(XV_AT)));
        end
        if (wren_d) begin
            mux2_d    = cnt_d[1:0];
            wrc_d     = {col_d, cnt_d[1:0]};
            rec_idx_d = {col_d, cnt_d[1:0], 1'b0};
        end
    end

    // State and output registers; reset abandons any block in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            twr_cnt_q <= '0;
            dly_q     <= '0;
            blocks_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdc_q     <= '0;
            x_valid_q <= 1'b0;
            mux1_q    <= 1'b0;
            trd_q     <= 1'b0;
            wren_q    <= 1'b0;
            wrc_q     <= '0;
            mux2_q    <= '0;
            rec_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            twr_cnt_q <= twr_cnt_d;
            dly_q     <= dly_d;
            blocks_q  <= blocks_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdc_q     <= rdc_d;
            x_valid_q <= x_valid_d;
            mux1_q    <= mux1_d;
            trd_q     <= trd_d;
            wren_q    <= wren_d;
            wrc_q     <= wrc_d;
            mux2_q    <= mux2_d;
            rec_idx_q <= rec_idx_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign blocks_o  = blocks_q;
    assign rdc_o     = 9'(rdc_q);
    assign x_valid_o = x_valid_q;
    assign mux1_o    = mux1_q;
    assign twr_o     = dly_q[DCT_LAT-1];
    assign trd_o     = trd_q;
    assign wren_o    = wren_q;
    assign wrc_o     = wrc_q;
    assign mux2_o    = mux2_q;
    assign rec_idx_o = rec_idx_q;

endmodule

// File: tb/tb_jpeg_dct_seq.sv
// Bench for jpeg_dct_seq: three instances (default, fastest, slowest latencies) compared
// cycle by cycle against a timetable model built from the block schedule.
module tb_jpeg_dct_seq;
    logic clk = 1'b0;
    logic rst;
    logic start;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Instance outputs: 0 = (4,1), a = (1,0), b = (15,3)
    logic busy0, done0, xv0, m10, twr0, trd0, wr0;
    logic [15:0] blk0; logic [8:0] rdc0; logic [4:0] wrc0; logic [1:0] m20; logic [5:0] rec0;
    logic busya, donea, xva, m1a, twra, trda, wra;
    logic [15:0] blka; logic [8:0] rdca; logic [4:0] wrca; logic [1:0] m2a; logic [5:0] reca;
    logic busyb, doneb, xvb, m1b, twrb, trdb, wrb;
    logic [15:0] blkb; logic [8:0] rdcb; logic [4:0] wrcb; logic [1:0] m2b; logic [5:0] recb;

    jpeg_dct_seq #(.DCT_LAT(4), .T_LAT(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy0), .done_o(done0),
        .blocks_o(blk0), .rdc_o(rdc0), .x_valid_o(xv0), .mux1_o(m10), .twr_o(twr0),
        .trd_o(trd0), .wren_o(wr0), .wrc_o(wrc0), .mux2_o(m20), .rec_idx_o(rec0));
    jpeg_dct_seq #(.DCT_LAT(1), .T_LAT(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busya), .done_o(donea),
        .blocks_o(blka), .rdc_o(rdca), .x_valid_o(xva), .mux1_o(m1a), .twr_o(twra),
        .trd_o(trda), .wren_o(wra), .wrc_o(wrca), .mux2_o(m2a), .rec_idx_o(reca));
    jpeg_dct_seq #(.DCT_LAT(15), .T_LAT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busyb), .done_o(doneb),
        .blocks_o(blkb), .rdc_o(rdcb), .x_valid_o(xvb), .mux1_o(m1b), .twr_o(twrb),
        .trd_o(trdb), .wren_o(wrb), .wrc_o(wrcb), .mux2_o(m2b), .rec_idx_o(recb));

    logic [28:0] obs0, obsa, obsb;
    assign obs0 = {busy0, done0, xv0, m10, twr0, trd0, wr0, wrc0, m20, rec0, rdc0};
    assign obsa = {busya, donea, xva, m1a, twra, trda, wra, wrca, m2a, reca, rdca};
    assign obsb = {busyb, doneb, xvb, m1b, twrb, trdb, wrb, wrcb, m2b, recb, rdcb};

    // Expected outputs t cycles after the first row-pass cycle, from the block timetable.
    function automatic logic [28:0] model(input int d, input int tl, input int t);
        logic busy, done, xv, m1, twr, trd, wr;
        int c0, per, c, r, p, wrc, m2, rec, rdc;
        busy = 0; done = 0; xv = 0; m1 = 0; twr = 0; trd = 0; wr = 0;
        wrc = 0; m2 = 0; rec = 0; rdc = 0;
        if (t < 0) return '0;
        c0  = 17 + d;
        per = 5 + tl + d;
        busy = (t <= c0 + 8 * per);
        done = (t == c0 + 8 * per);
        if (t < 16) rdc = t;
        xv  = (t >= 2) && (t <= 16) && (t % 2 == 0);
        twr = (t - d >= 2) && (t - d <= 16) && ((t - d) % 2 == 0);
        if (t >= c0 && t < c0 + 8 * per) begin
            c   = (t - c0) / per;
            r   = (t - c0) % per;
            trd = (r == 0);
            xv  = xv || (r == tl);
            m1  = (r <= tl + d);
            if (r > tl + d) begin
                wr  = 1;
                p   = r - tl - d - 1;
                wrc = 4 * c + p;
                m2  = p;
                rec = 8 * c + 2 * p;
            end
        end
        return {busy, done, xv, m1, twr, trd, wr, 5'(wrc), 2'(m2), 6'(rec), 9'(rdc)};
    endfunction

    task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One default-latency block from a start pulse; optional random start_i noise while busy.
    task automatic run_block(input bit noise, input logic [15:0] exp_blk);
        start = 1'b1;
        step();
        for (int t = 0; t <= 110; t++) begin
            check("blk", t, 32'(obs0), 32'(model(4, 1, t)));
            if (t == 58) check("rec_at_wrc13", t, 32'({wrc0, rec0}), 32'({5'd13, 6'd26}));
            if (t == 102) check("blocks", t, 32'(blk0), 32'(exp_blk));
            start = (noise && t <= 101) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check("rst_out0", 0, 32'(obs0), 32'd0);
        check("rst_outa", 0, 32'(obsa), 32'd0);
        check("rst_outb", 0, 32'(obsb), 32'd0);
        check("rst_blk0", 0, 32'(blk0), 32'd0);
        rst = 1'b0;

        // Idle with start low: nothing moves.
        for (int t = 0; t < 50; t++) begin
            check("idle", t, 32'(obs0), 32'd0);
            step();
        end
        repeat ($urandom_range(1, 4)) step();

        // Single block, start_i noise during the block must be ignored.
        run_block(1'b1, 16'd1);

        // Back-to-back with start held high: next accept only after DONE.
        start = 1'b1;
        step();
        for (int t = 0; t <= 205; t++) begin
            check("b2b", t, 32'(obs0), 32'(t < 103 ? model(4, 1, t) : model(4, 1, t - 103)));
            if (t == 205) begin
                check("b2b_blocks", t, 32'(blk0), 32'd3);
                start = 1'b0;
            end
            step();
        end
        repeat ($urandom_range(1, 4)) step();

        // Asynchronous reset in the middle of a block.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 50; t++) begin
            check("pre_rst", t, 32'(obs0), 32'(model(4, 1, t)));
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", 50, 32'(obs0), 32'd0);
        check("async_rst_blk", 50, 32'(blk0), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            check("post_rst", t, 32'({obs0, blk0}), 32'd0);
            step();
        end
        run_block(1'b0, 16'd1);

        // Block counter wrap.
        force dut.blocks_q = 16'hFFFF;
        step();
        release dut.blocks_q;
        step();
        check("preload", 0, 32'(blk0), 32'h0000FFFF);
        run_block(1'b1, 16'h0000);

        // Latency sweep: all three instances from a common reset and start.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 225; t++) begin
            check("sweep_d4t1", t, 32'(obs0), 32'(model(4, 1, t)));
            check("sweep_d1t0", t, 32'(obsa), 32'(model(1, 0, t)));
            check("sweep_d15t3", t, 32'(obsb), 32'(model(15, 3, t)));
            step();
        end
        check("sweep_blk_a", 0, 32'(blka), 32'd1);
        check("sweep_blk_b", 0, 32'(blkb), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
